// File: rtl/output_preprocessor_mc.sv
// output_preprocessor_mc: multi-channel scale/accumulate/slew/clamp stage
// between the tagged PID stream and the DAC/DDS consumers.
module output_preprocessor_mc #(
  parameter int W_IN         = 18,
  parameter int W_OUT        = 16,
  parameter int W_MULT       = 8,
  parameter int N_CHAN       = 8,
  parameter int W_CHAN       = 3,
  parameter int COMP_LATENCY = 3
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic signed [W_IN-1:0]   data_in,
  input  logic [W_CHAN-1:0]        chan_in,
  input  logic                     data_valid_in,
  output logic                     ready_out,
  input  logic [N_CHAN-1:0]        lock_en_in,
  input  logic                     param_wr_en_in,
  input  logic [W_CHAN-1:0]        param_chan_in,
  input  logic [2:0]               param_addr_in,
  input  logic [W_OUT-1:0]         param_data_in,
  input  logic [N_CHAN-1:0]        update_en_in,
  input  logic                     update_in,
  output logic signed [W_OUT-1:0]  data_out,
  output logic [W_CHAN-1:0]        chan_out,
  output logic                     data_valid_out
);

  localparam int W_P   = W_OUT + W_MULT;
  localparam int W_S   = W_P + 2;
  localparam int W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int W_CNT = (COMP_LATENCY > 1) ? $clog2(COMP_LATENCY + 1) : 1;

  localparam logic signed [W_OUT-1:0] MAX_RST =
    {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_OUT-1:0] MIN_RST =
    {1'b1, {(W_OUT-1){1'b0}}};
  localparam logic signed [W_MULT-1:0] MULT_RST = W_MULT'(1);
  localparam logic [W_CHAN:0] N_CHAN_W = (W_CHAN+1)'(N_CHAN);
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(COMP_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t state_q, state_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic signed [W_OUT-1:0] sample_q, sample_d;
  logic [W_CHAN-1:0] chan_q, chan_d;
  logic signed [W_OUT-1:0] data_out_q, data_out_d;
  logic [W_CHAN-1:0] chan_out_q, chan_out_d;

  logic signed [W_OUT-1:0]  max_q [N_CHAN];
  logic signed [W_OUT-1:0]  max_d [N_CHAN];
  logic signed [W_OUT-1:0]  min_q [N_CHAN];
  logic signed [W_OUT-1:0]  min_d [N_CHAN];
  logic signed [W_OUT-1:0]  init_q [N_CHAN];
  logic signed [W_OUT-1:0]  init_d [N_CHAN];
  logic signed [W_MULT-1:0] mult_q [N_CHAN];
  logic signed [W_MULT-1:0] mult_d [N_CHAN];
  logic [W_OUT-1:0]         slew_q [N_CHAN];
  logic [W_OUT-1:0]         slew_d [N_CHAN];
  logic signed [W_OUT-1:0]  prev_q [N_CHAN];
  logic signed [W_OUT-1:0]  prev_d [N_CHAN];

  logic signed [W_OUT-1:0]  sh_max_q [N_CHAN];
  logic signed [W_OUT-1:0]  sh_max_d [N_CHAN];
  logic signed [W_OUT-1:0]  sh_min_q [N_CHAN];
  logic signed [W_OUT-1:0]  sh_min_d [N_CHAN];
  logic signed [W_OUT-1:0]  sh_init_q [N_CHAN];
  logic signed [W_OUT-1:0]  sh_init_d [N_CHAN];
  logic signed [W_MULT-1:0] sh_mult_q [N_CHAN];
  logic signed [W_MULT-1:0] sh_mult_d [N_CHAN];
  logic [W_OUT-1:0]         sh_slew_q [N_CHAN];
  logic [W_OUT-1:0]         sh_slew_d [N_CHAN];

  logic signed [W_OUT-1:0] raw;

  generate
    if (W_OUT < W_IN) begin : g_trunc
      logic unused_lsb;
      assign raw = data_in[W_IN-1 -: W_OUT];
      assign unused_lsb = ^data_in[W_IN-W_OUT-1:0];
    end else begin : g_ext
      assign raw = W_OUT'(data_in);
    end
  endgenerate

  logic [W_IDX-1:0] sel_idx;
  logic             sel_ok;
  logic [W_IDX-1:0] wr_idx;
  logic             wr_ok;

  assign sel_idx = chan_q[W_IDX-1:0];
  assign sel_ok  = {1'b0, chan_q} < N_CHAN_W;
  assign wr_idx  = param_chan_in[W_IDX-1:0];
  assign wr_ok   = param_wr_en_in &&
                   ({1'b0, param_chan_in} < N_CHAN_W);

  logic signed [W_OUT-1:0]  c_max;
  logic signed [W_OUT-1:0]  c_min;
  logic signed [W_OUT-1:0]  c_init;
  logic signed [W_MULT-1:0] c_mult;
  logic [W_OUT-1:0]         c_slew;
  logic signed [W_OUT-1:0]  c_prev;
  logic                     c_lock;

  // Active parameters of the latched channel; unknown tags use defaults
  always_comb begin
    c_max  = MAX_RST;
    c_min  = MIN_RST;
    c_init = '0;
    c_mult = MULT_RST;
    c_slew = '0;
    c_prev = '0;
    c_lock = 1'b1;
    if (sel_ok) begin
      c_max  = max_q[sel_idx];
      c_min  = min_q[sel_idx];
      c_init = init_q[sel_idx];
      c_mult = mult_q[sel_idx];
      c_slew = slew_q[sel_idx];
      c_prev = prev_q[sel_idx];
      c_lock = lock_en_in[sel_idx];
    end
  end

  logic signed [W_P-1:0]   prod;
  logic signed [W_S-1:0]   step;
  logic signed [W_S-1:0]   slew_lim;
  logic signed [W_S-1:0]   val;
  logic signed [W_OUT-1:0] result;

  // Full-precision scale, accumulate, slew-limit and clamp
  always_comb begin
    prod     = W_P'(sample_q) * W_P'(c_mult);
    step     = W_S'(prod);
    slew_lim = $signed({{(W_S-W_OUT){1'b0}}, c_slew});
    if (c_slew != '0) begin
      if (step > slew_lim) begin
        step = slew_lim;
      end else if (step < -slew_lim) begin
        step = -slew_lim;
      end
    end
    val = c_lock ? (W_S'(c_prev) + step) : W_S'(c_init);
    if (val > W_S'(c_max)) begin
      val = W_S'(c_max);
    end
    if (val < W_S'(c_min)) begin
      val = W_S'(c_min);
    end
    result = val[W_OUT-1:0];
  end

  // Sequencer: latch, wait, load outputs, write back
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sample_d   = sample_q;
    chan_d     = chan_q;
    data_out_d = data_out_q;
    chan_out_d = chan_out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (data_valid_in) begin
          state_d  = ST_COMPUTE;
          cnt_d    = '0;
          sample_d = raw;
          chan_d   = chan_in;
        end
      end
      ST_COMPUTE: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_SEND;
          data_out_d = result;
          chan_out_d = chan_q;
        end else begin
          cnt_d = cnt_q + W_CNT'(1);
        end
      end
      ST_SEND: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow writes, DONE writeback and update commit (update wins)
  always_comb begin
    for (int i = 0; i < N_CHAN; i++) begin
      max_d[i]     = max_q[i];
      min_d[i]     = min_q[i];
      init_d[i]    = init_q[i];
      mult_d[i]    = mult_q[i];
      slew_d[i]    = slew_q[i];
      prev_d[i]    = prev_q[i];
      sh_max_d[i]  = sh_max_q[i];
      sh_min_d[i]  = sh_min_q[i];
      sh_init_d[i] = sh_init_q[i];
      sh_mult_d[i] = sh_mult_q[i];
      sh_slew_d[i] = sh_slew_q[i];
    end
    if (wr_ok) begin
      unique case (param_addr_in)
        3'd0: sh_max_d[wr_idx]  = param_data_in;
        3'd1: sh_min_d[wr_idx]  = param_data_in;
        3'd2: sh_init_d[wr_idx] = param_data_in;
        3'd3: sh_mult_d[wr_idx] = param_data_in[W_MULT-1:0];
        3'd4: sh_slew_d[wr_idx] = param_data_in;
        default: ;
      endcase
    end
    if ((state_q == ST_DONE) && sel_ok) begin
      prev_d[sel_idx] = data_out_q;
    end
    if (update_in) begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (update_en_in[i]) begin
          max_d[i]  = sh_max_q[i];
          min_d[i]  = sh_min_q[i];
          init_d[i] = sh_init_q[i];
          mult_d[i] = sh_mult_q[i];
          slew_d[i] = sh_slew_q[i];
          prev_d[i] = sh_init_q[i];
        end
      end
    end
  end

  // State, datapath and both parameter banks
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sample_q   <= '0;
      chan_q     <= '0;
      data_out_q <= '0;
      chan_out_q <= '0;
      for (int i = 0; i < N_CHAN; i++) begin
        max_q[i]     <= MAX_RST;
        min_q[i]     <= MIN_RST;
        init_q[i]    <= '0;
        mult_q[i]    <= MULT_RST;
        slew_q[i]    <= '0;
        prev_q[i]    <= '0;
        sh_max_q[i]  <= MAX_RST;
        sh_min_q[i]  <= MIN_RST;
        sh_init_q[i] <= '0;
        sh_mult_q[i] <= MULT_RST;
        sh_slew_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sample_q   <= sample_d;
      chan_q     <= chan_d;
      data_out_q <= data_out_d;
      chan_out_q <= chan_out_d;
      for (int i = 0; i < N_CHAN; i++) begin
        max_q[i]     <= max_d[i];
        min_q[i]     <= min_d[i];
        init_q[i]    <= init_d[i];
        mult_q[i]    <= mult_d[i];
        slew_q[i]    <= slew_d[i];
        prev_q[i]    <= prev_d[i];
        sh_max_q[i]  <= sh_max_d[i];
        sh_min_q[i]  <= sh_min_d[i];
        sh_init_q[i] <= sh_init_d[i];
        sh_mult_q[i] <= sh_mult_d[i];
        sh_slew_q[i] <= sh_slew_d[i];
      end
    end
  end

  assign ready_out      = (state_q == ST_IDLE);
  assign data_valid_out = (state_q == ST_SEND);
  assign data_out       = data_out_q;
  assign chan_out       = chan_out_q;

endmodule

// File: tb/tb_output_preprocessor_mc.sv
// tb_output_preprocessor_mc: directed plan plus random traffic checked
// every cycle against a timeline model of the preprocessor.
module tb_output_preprocessor_mc;

  localparam int CL = 3;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [17:0] data_in;
  logic [2:0]  chan_in;
  logic        data_valid_in;
  logic        ready_out;
  logic [7:0]  lock_en_in;
  logic        param_wr_en_in;
  logic [2:0]  param_chan_in;
  logic [2:0]  param_addr_in;
  logic [15:0] param_data_in;
  logic [7:0]  update_en_in;
  logic        update_in;
  logic [15:0] data_out;
  logic [2:0]  chan_out;
  logic        data_valid_out;

  always #5 clk = ~clk;

  output_preprocessor_mc #(
    .W_IN(18), .W_OUT(16), .W_MULT(8),
    .N_CHAN(8), .W_CHAN(3), .COMP_LATENCY(CL)
  ) dut (
    .clk_in(clk),
    .reset_in(reset_in),
    .data_in(data_in),
    .chan_in(chan_in),
    .data_valid_in(data_valid_in),
    .ready_out(ready_out),
    .lock_en_in(lock_en_in),
    .param_wr_en_in(param_wr_en_in),
    .param_chan_in(param_chan_in),
    .param_addr_in(param_addr_in),
    .param_data_in(param_data_in),
    .update_en_in(update_en_in),
    .update_in(update_in),
    .data_out(data_out),
    .chan_out(chan_out),
    .data_valid_out(data_valid_out)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // params per channel: 0 max, 1 min, 2 init, 3 mult, 4 slew
  logic [15:0] m_sh  [8][5];
  logic [15:0] m_act [8][5];
  longint      m_prev [8];
  int          age;
  logic [2:0]  m_ch;
  logic [17:0] m_d;
  logic [15:0] m_out;
  logic [2:0]  m_outch;

  function automatic logic [15:0] calc(
    input logic [15:0] mx, input logic [15:0] mn,
    input logic [15:0] ini, input logic [15:0] mu,
    input logic [15:0] sl, input longint pv,
    input logic [17:0] d, input logic lock);
    longint raw, mul, step, slim, v, hi, lo;
    logic [15:0] r;
    raw  = longint'($signed(d[17:2]));
    mul  = longint'($signed(mu[7:0]));
    step = raw * mul;
    slim = longint'(sl);
    if (slim != 0) begin
      if (step > slim) step = slim;
      if (step < -slim) step = -slim;
    end
    v  = lock ? pv + step : longint'($signed(ini));
    hi = longint'($signed(mx));
    lo = longint'($signed(mn));
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    r = v[15:0];
    return r;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 8; c++) begin
      m_act[c][0] = 16'h7FFF; m_sh[c][0] = 16'h7FFF;
      m_act[c][1] = 16'h8000; m_sh[c][1] = 16'h8000;
      m_act[c][2] = 16'h0000; m_sh[c][2] = 16'h0000;
      m_act[c][3] = 16'h0001; m_sh[c][3] = 16'h0001;
      m_act[c][4] = 16'h0000; m_sh[c][4] = 16'h0000;
      m_prev[c] = 0;
    end
    age = 0;
    m_out = '0;
    m_outch = '0;
  endtask

  // Cycle-accurate view of the sample timeline and both banks
  always @(posedge clk) begin
    if (reset_in) begin
      m_reset();
    end else begin
      if (age == CL) begin
        m_out = calc(m_act[m_ch][0], m_act[m_ch][1], m_act[m_ch][2],
                     m_act[m_ch][3], m_act[m_ch][4], m_prev[m_ch],
                     m_d, lock_en_in[m_ch]);
        m_outch = m_ch;
      end
      if (age == CL + 2)
        m_prev[m_outch] = longint'($signed(m_out));
      if (update_in) begin
        for (int c = 0; c < 8; c++) begin
          if (update_en_in[c]) begin
            for (int k = 0; k < 5; k++) m_act[c][k] = m_sh[c][k];
            m_prev[c] = longint'($signed(m_sh[c][2]));
          end
        end
      end
      if (param_wr_en_in && param_addr_in < 3'd5)
        m_sh[param_chan_in][param_addr_in] = param_data_in;
      if (age == 0) begin
        if (data_valid_in) begin
          age  = 1;
          m_ch = chan_in;
          m_d  = data_in;
        end
      end else if (age == CL + 2) begin
        age = 0;
      end else begin
        age++;
      end
    end
  end

  bit chk_en = 1'b0;

  // Compare DUT against the model on every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(ready_out), 32'(age == 0));
      check("valid", 32'(data_valid_out), 32'(age == CL + 1));
      check("data_out", 32'(data_out), 32'(m_out));
      check("chan_out", 32'(chan_out), 32'(m_outch));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [2:0] a,
                    input logic [15:0] d);
    param_wr_en_in = 1'b1;
    param_chan_in  = ch;
    param_addr_in  = a;
    param_data_in  = d;
    tick();
    param_wr_en_in = 1'b0;
  endtask

  task automatic upd(input logic [7:0] m);
    update_in    = 1'b1;
    update_en_in = m;
    tick();
    update_in    = 1'b0;
    update_en_in = '0;
  endtask

  task automatic send(input logic [2:0] ch, input logic [17:0] d,
                      output logic [15:0] res, output int lat);
    int n;
    n = 0;
    while (!ready_out && n < 50) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(n < 50), 32'd1);
    data_valid_in = 1'b1;
    chan_in = ch;
    data_in = d;
    tick();
    data_valid_in = 1'b0;
    lat = 1;
    while (!data_valid_out && lat < 20) begin
      tick();
      lat++;
    end
    res = data_out;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    logic [17:0] rd;
    int lat;
    reset_in = 1'b1;
    data_in = '0;
    chan_in = '0;
    data_valid_in = 1'b0;
    lock_en_in = 8'hFF;
    param_wr_en_in = 1'b0;
    param_chan_in = '0;
    param_addr_in = '0;
    param_data_in = '0;
    update_en_in = '0;
    update_in = 1'b0;
    tick();
    chk_en = 1'b1;
    reset_in = 1'b0;
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_valid", 32'(data_valid_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_chan", 32'(chan_out), 32'd0);
    tick();

    send(3'd2, 18'h00400, r, lat);
    check("t1_data", 32'(r), 32'h0100);
    check("t1_lat", 32'(lat), 32'(CL + 1));
    check("t1_chan", 32'(chan_out), 32'd2);
    tick();
    check("t1_busy_done", 32'(ready_out), 32'd0);
    send(3'd2, 18'h00400, r, lat);
    check("t1_data2", 32'(r), 32'h0200);

    send(3'd0, 18'h00400, r, lat);
    send(3'd0, 18'h00400, r, lat);
    send(3'd0, 18'h00400, r, lat);
    check("iso_ch0", 32'(r), 32'h0300);
    send(3'd5, 18'h00040, r, lat);
    check("iso_ch5", 32'(r), 32'h0010);
    send(3'd0, 18'h00400, r, lat);
    check("iso_ch0b", 32'(r), 32'h0400);

    wr(3'd1, 3'd0, 16'h1000);
    wr(3'd1, 3'd1, 16'hF000);
    wr(3'd1, 3'd3, 16'h007F);
    upd(8'h02);
    send(3'd1, 18'h1FFFC, r, lat);
    check("sat_pos", 32'(r), 32'h1000);
    send(3'd1, 18'h20000, r, lat);
    check("sat_neg", 32'(r), 32'hF000);

    wr(3'd3, 3'd4, 16'h0020);
    upd(8'h08);
    send(3'd3, 18'h00400, r, lat);
    check("slew1", 32'(r), 32'h0020);
    send(3'd3, 18'h00400, r, lat);
    check("slew2", 32'(r), 32'h0040);
    send(3'd3, 18'h00400, r, lat);
    check("slew3", 32'(r), 32'h0060);

    wr(3'd4, 3'd2, 16'h0555);
    upd(8'h10);
    lock_en_in[4] = 1'b0;
    rd = 18'($urandom);
    send(3'd4, rd, r, lat);
    check("unlock1", 32'(r), 32'h0555);
    wr(3'd4, 3'd2, 16'h0123);
    wr(3'd4, 3'd3, 16'h0040);
    rd = 18'($urandom);
    send(3'd4, rd, r, lat);
    check("unlock2", 32'(r), 32'h0555);
    lock_en_in = 8'hFF;

    while (!ready_out) tick();
    data_valid_in = 1'b1;
    chan_in = 3'd2;
    data_in = 18'h00400;
    tick();
    data_valid_in = 1'b0;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check("rstmid_ready", 32'(ready_out), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("rstmid_nostrobe", 32'(data_valid_out), 32'd0);
      tick();
    end
    send(3'd2, 18'h00400, r, lat);
    check("rstmid_prev", 32'(r), 32'h0100);

    for (int i = 0; i < 3000; i++) begin
      data_valid_in = 1'($urandom_range(0, 1));
      chan_in = 3'($urandom);
      data_in = 18'($urandom);
      if ($urandom_range(0, 7) == 0) lock_en_in = 8'($urandom);
      param_wr_en_in = ($urandom_range(0, 3) == 0);
      param_chan_in = 3'($urandom);
      param_addr_in = 3'($urandom);
      if ($urandom_range(0, 1) == 0)
        param_data_in = 16'($urandom_range(0, 255));
      else
        param_data_in = 16'($urandom);
      update_in = ($urandom_range(0, 15) == 0);
      update_en_in = 8'($urandom);
      reset_in = ($urandom_range(0, 499) == 0);
      tick();
    end
    data_valid_in = 1'b0;
    param_wr_en_in = 1'b0;
    update_in = 1'b0;
    reset_in = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/output_preprocessor_mc.md
# output_preprocessor_mc

- Multi-channel, parametrised successor to the single-channel output preprocessor.
- Sits between the channel-tagged PID/mux output stream and the DAC instruction queue / DDS controller.
- Keeps independent accumulator, multiplier, init and bounds for each of N_CHAN channels, and adds per-channel slew-rate limiting and saturating arithmetic.
- Double-buffers all frontpanel parameters (shadow bank → active bank on update) and exposes an explicit ready handshake.

## Interface
- W_IN, 18: input data width
- W_OUT, 16: output data width; all per-channel parameters are this width except multiplier
- W_MULT, 8: signed multiplier width
- N_CHAN, 8: channel count (≥2)
- W_CHAN, 3: channel tag width, ≥ clog2(N_CHAN)
- COMP_LATENCY, 3: cycles spent in ST_COMPUTE (≥1)
- clk_in  in  1  system clock; the block uses this one clock only
- reset_in  in  1  synchronous, active-high reset
- data_in  in  W_IN  signed input sample
- chan_in  in  W_CHAN  channel tag of data_in
- data_valid_in  in  1  sample valid; accepted only on a cycle where ready_out=1
- ready_out  out  1  high only in ST_IDLE
- lock_en_in  in  N_CHAN  per-channel lock enable, sampled live
- param_wr_en_in  in  1  write param_data_in to the shadow bank
- param_chan_in  in  W_CHAN  shadow write channel
- param_addr_in  in  3  parameter select: 0 max, 1 min, 2 init, 3 multiplier (low W_MULT bits), 4 slew_max (unsigned); 5–7 ignored
- param_data_in  in  W_OUT  shadow write data
- update_en_in  in  N_CHAN  per-channel update enable
- update_in  in  1  single-cycle pulse; commits shadow→active for every enabled channel
- data_out  out  W_OUT  signed result, registered
- chan_out  out  W_CHAN  channel tag of data_out
- data_valid_out  out  1  one-cycle strobe in ST_SEND

## Operation
- States: ST_IDLE, ST_COMPUTE, ST_SEND, ST_DONE.
  - IDLE→COMPUTE on data_valid_in. Sample and tag are latched on that edge.
  - COMPUTE→SEND after COMP_LATENCY cycles.
  - SEND→DONE after 1 cycle.
  - DONE→IDLE after 1 cycle.
  - Samples presented while ready_out=0 are ignored and not queued.
- Channel tags ≥ N_CHAN are accepted. They produce data_valid_out but write back nothing (no prev update).
- Width conversion: raw = data_in[W_IN-1 -: W_OUT] if W_OUT<W_IN, else sign-extended data_in.
- Arithmetic for channel c (all signed, full precision, no wrap):
  - p = raw*mult[c], width W_OUT+W_MULT.
  - s = p + prev[c].
  - If slew_max[c]≠0, clamp the step (s−prev[c]) to ±slew_max[c].
  - v = lock_en_in[c] ? s : init[c].
  - Clamp v to ≤max[c], then to ≥min[c]. min wins if min>max.
  - The result is exact in W_OUT.
- data_out and chan_out load on entering ST_SEND and hold until the next SEND.
- In ST_DONE, prev[chan] ← data_out.
- update_in with update_en_in[c]=1: active params[c] ← shadow[c] and prev[c] ← shadow init[c], in the same cycle.
  - If this coincides with the ST_DONE writeback to c, the update wins.
- A shadow write and an update_in in the same cycle: the update commits the pre-write shadow value.
- Reset values:
  - Active and shadow banks: max=+2^(W_OUT-1)−1, min=−2^(W_OUT-1), init=0, mult=1, slew_max=0.
  - prev=0.
  - State ST_IDLE.
  - Outputs: data_out=0, chan_out=0, data_valid_out=0, ready_out=1 in the first cycle after reset.
- Reset mid-operation aborts the sample with no output strobe and no writeback.

## Timing
- Accept edge T: data_valid_in & ready_out sampled high.
- ready_out falls at T+1 (state is COMPUTE).
- data_valid_out is high for exactly the cycle T+COMP_LATENCY+1.
- prev writeback takes effect at edge T+COMP_LATENCY+2.
- ready_out is high again at T+COMP_LATENCY+3. Peak throughput is one sample per COMP_LATENCY+3 cycles.
- Parameter changes take effect only on the update_in edge.
- lock_en_in is sampled combinationally during ST_COMPUTE/SEND entry.

## Test plan
- Reset, then ch2 defaults, lock_en[2]=1, data_in=18'h00400 (raw=0x0100), COMP_LATENCY=3.
  - Required: data_valid_out high exactly at T+4.
  - data_out=0x0100, chan_out=2.
  - A second identical sample gives 0x0200.
  - ready_out low T+1..T+5.
- Channel isolation: accumulate ch0 to 0x0300, then send one sample on ch5 (raw=0x0010, mult=1).
  - Required: ch5 result 0x0010.
  - Next ch0 sample with raw 0x0100 gives 0x0400.
- Clamp and saturation on ch1: max=0x1000, min=−0x1000, mult=127, raw=0x7FFF, update.
  - Required: output 0x1000, no wrap.
  - Negative raw gives 0xF000.
- Slew limit on ch3: slew_max=0x0020, mult=1, raw=0x0100, prev=0.
  - Required: outputs 0x0020, 0x0040, 0x0060 on successive samples.
- Lock disabled and update semantics on ch4: init=0x0555, update_en[4]=1, pulse update, lock_en[4]=0.
  - Required: output 0x0555 regardless of data_in.
  - Shadow writes without update_in do not change the output.
- Reset asserted at T+2 mid-compute.
  - Required: no data_valid_out strobe.
  - prev unchanged from reset value 0.
  - ready_out=1 the cycle after reset deasserts.
